vga_wr_master: RTL and testbench

Bus-side initiator for the video RAM window. It accepts CPU byte writes into a small FIFO and replays each one onto the video bus (a, d, n_we, n_oe, ena). Each write is stalled while the video controller reports the RAM busy through n_rdy (active pixel area), and is retried if the controller revokes readiness mid-strobe. It sits between the CPU write path and the VGA controller, so the CPU never has to spin on n_rdy itself.

---
 rtl/vga_wr_master.sv | 121 ++++++++++++
 tb/tb_vga_wr_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_wr_master.sv
// CPU-to-video-RAM write initiator: queues in-window byte writes and replays each on the video bus,
// stalling on n_rdy and retrying a strobe that the controller revokes.
module vga_wr_master #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned WE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [15:0]              wr_addr,
  input  logic [7:0]               wr_data,
  output logic                     wr_ready,
  output logic                     wr_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic [15:0]              a,
  output logic [7:0]               d,
  output logic                     n_we,
  output logic                     n_oe,
  output logic                     ena,
  input  logic                     n_rdy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

  typedef logic [AW:0]   ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t CntInit = cnt_t'(WE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e      state_q;
  cnt_t        cnt_q;
  ptr_t        wptr_q, rptr_q;
  logic [15:0] addr_mem [DEPTH];
  logic [7:0]  data_mem [DEPTH];

  logic in_win, full, empty, push, pop;

  // Window 0xD000-0xEFFF: top bits 11 and exactly one of bits 13/12 set.
  assign in_win = (wr_addr[15:14] == 2'b11) && (wr_addr[13] ^ wr_addr[12]);

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign push  = wr_valid & ~full & in_win;
  assign pop   = (state_q == StHold);

  assign wr_ready = ~full;
  assign level    = wptr_q - rptr_q;
  assign busy     = ~empty | (state_q != StIdle);
  assign n_oe     = 1'b1;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr_q[AW-1:0]] <= wr_addr;
      data_mem[wptr_q[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      wr_err <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + ptr_t'(1);
      if (pop)  rptr_q <= rptr_q + ptr_t'(1);
      wr_err <= wr_valid & ~in_win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a       <= '0;
      d       <= '0;
      n_we    <= 1'b1;
      ena     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            state_q <= StSetup;
            a       <= addr_mem[rptr_q[AW-1:0]];
            d       <= data_mem[rptr_q[AW-1:0]];
            ena     <= 1'b1;
          end
        end
        StSetup: begin
          if (!n_rdy) begin
            state_q <= StStrobe;
            cnt_q   <= CntInit;
            n_we    <= 1'b0;
          end
        end
        StStrobe: begin
          // Revoked readiness aborts the strobe; the entry stays at the head for a retry.
          if (n_rdy) begin
            state_q <= StSetup;
            n_we    <= 1'b1;
          end else if (cnt_q == '0) begin
            state_q <= StHold;
            n_we    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        StHold: begin
          state_q <= StIdle;
          ena     <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_wr_master.sv
// Self-checking bench for vga_wr_master: directed scenarios plus randomized traffic checked by a
// transaction-level model of accepted writes and the bus protocol rules.
module tb_vga_wr_master;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WE    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        n_rdy = 1'b1;
  logic        wr_ready, wr_err, busy, n_we, n_oe, ena;
  logic [2:0]  level;
  logic [15:0] a;
  logic [7:0]  d;

  int n_chk = 0;
  int n_fail = 0;

  vga_wr_master #(.DEPTH(DEPTH), .WE_CYCLES(WE)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .wr_err   (wr_err),
    .level    (level),
    .busy     (busy),
    .a        (a),
    .d        (d),
    .n_we     (n_we),
    .n_oe     (n_oe),
    .ena      (ena),
    .n_rdy    (n_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [15:0] ad, input logic [7:0] dt);
    wr_valid = 1'b1;
    wr_addr  = ad;
    wr_data  = dt;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    n_rdy = 1'b0;
    k = 0;
    while (busy && k < 200) begin
      step();
      k++;
    end
    check(tag, busy, 1'b0);
    check({tag, "_lvl"}, level, 0);
  endtask

  function automatic bit in_win(input logic [15:0] ad);
    return (ad >= 16'hD000) && (ad <= 16'hEFFF);
  endfunction

  // Model: queue of accepted writes; every completed strobe must carry the oldest one.
  logic [23:0] mq[$];
  bit          seen_rst = 0;
  bit          pop_pend = 0;
  int          low_run = 0;
  logic        p_nwe, p_ena;
  logic [15:0] p_a;
  logic [7:0]  p_d;

  always @(posedge clk) begin
    logic        r, v, nr, had_pend;
    logic [15:0] wa;
    logic [7:0]  wd;
    int          sz;
    bit          acc;
    r = rst; v = wr_valid; wa = wr_addr; wd = wr_data; nr = n_rdy;
    #2;
    if (r) begin
      mq.delete();
      pop_pend = 0;
      low_run  = 0;
      seen_rst = 1;
      check("m_rst_lvl", level, 0);
      check("m_rst_bus", {ena, n_we, n_oe, wr_ready, wr_err}, 5'b01110);
      check("m_rst_ad", {a, d}, 24'h0);
    end else if (seen_rst) begin
      sz = mq.size();
      acc = v && in_win(wa) && (sz < DEPTH);
      had_pend = pop_pend;
      if (pop_pend) begin
        if (mq.size() > 0) void'(mq.pop_front());
        pop_pend = 0;
      end
      if (acc) mq.push_back({wa, wd});
      check("m_level", level, mq.size());
      check("m_ready", wr_ready, mq.size() < DEPTH);
      check("m_err", wr_err, v && !in_win(wa));
      check("m_noe", n_oe, 1'b1);
      check("m_busy", busy, (mq.size() != 0) || ena);
      if (had_pend) check("m_hold_len", {ena, n_we}, 2'b01);
      if ({a, d} !== {p_a, p_d}) check("m_ad_change", {p_ena, ena}, 2'b01);
      if (ena && !p_ena) begin
        if (mq.size() == 0) check("m_setup_nodata", 1'b1, 1'b0);
        else check("m_setup_head", {a, d}, mq[0]);
      end
      if (!n_we) begin
        low_run++;
        check("m_strobe_ena", ena, 1'b1);
        if (p_nwe) check("m_addr_setup", p_ena, 1'b1);
        if (low_run > WE) check("m_strobe_long", low_run, WE);
      end else if (!p_nwe) begin
        if (low_run == WE && !nr) begin
          if (mq.size() == 0) check("m_write_nodata", 1'b1, 1'b0);
          else check("m_write", {a, d}, mq[0]);
          pop_pend = 1;
        end else begin
          check("m_abort_cause", nr, 1'b1);
        end
        low_run = 0;
      end
    end
    p_nwe = n_we; p_ena = ena; p_a = a; p_d = d;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    check("rst_lvl", level, 0);
    check("rst_bus", {ena, n_we, n_oe, busy, wr_ready}, 5'b01101);
    rst = 1'b0;
    n_rdy = 1'b0;
    step();

    // Best-case single write
    put(16'hD005, 8'h41);
    check("t1_lvl1", level, 1);
    check("t1_idle", ena, 1'b0);
    step();
    check("t1_setup", {ena, n_we, a, d}, {2'b11, 16'hD005, 8'h41});
    step();
    check("t1_we0a", n_we, 1'b0);
    step();
    check("t1_we0b", n_we, 1'b0);
    step();
    check("t1_hold", {ena, n_we}, 2'b11);
    check("t1_hold_lvl", level, 1);
    step();
    check("t1_pop", {level, ena, busy}, {3'd0, 1'b0, 1'b0});

    // Long stall in SETUP
    n_rdy = 1'b1;
    put(16'hE010, 8'h07);
    step(101);
    check("t2_stall", {ena, n_we, a, d}, {2'b11, 16'hE010, 8'h07});
    n_rdy = 1'b0;
    step();
    check("t2_we0", n_we, 1'b0);
    step(2);
    check("t2_hold", {ena, n_we}, 2'b11);
    step();
    check("t2_done", {level, busy}, {3'd0, 1'b0});

    // Abort in first strobe cycle, then full retry
    put(16'hE010, 8'h07);
    step(2);
    check("t3_strobe", n_we, 1'b0);
    n_rdy = 1'b1;
    step();
    check("t3_abort", {ena, n_we, level}, {2'b11, 3'd1});
    n_rdy = 1'b0;
    step();
    check("t3_retry", {n_we, a, d}, {1'b0, 16'hE010, 8'h07});
    step();
    check("t3_retry2", n_we, 1'b0);
    step();
    check("t3_hold", {ena, n_we}, 2'b11);
    step();
    check("t3_done", level, 0);

    // Overfill with controller busy
    n_rdy = 1'b1;
    wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_addr = 16'hD100 + 16'(i);
      wr_data = 8'h50 + 8'(i);
      step();
      if (i == 3) check("t4_full", wr_ready, 1'b0);
    end
    wr_valid = 1'b0;
    check("t4_lvl", level, DEPTH);
    drain("t4_drain");

    // Window boundaries
    n_rdy = 1'b1;
    put(16'hC000, 8'h01);
    check("t5_err_c000", {wr_err, level}, {1'b1, 3'd0});
    step();
    check("t5_err_clr", wr_err, 1'b0);
    put(16'hF123, 8'h02);
    check("t5_err_f123", {wr_err, level}, {1'b1, 3'd0});
    put(16'hDFFF, 8'h03);
    check("t5_dfff", {wr_err, level}, {1'b0, 3'd1});
    put(16'hE000, 8'h04);
    check("t5_e000", {wr_err, level}, {1'b0, 3'd2});
    drain("t5_drain");

    // Reset mid-strobe with entries queued
    n_rdy = 1'b1;
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_addr = 16'hD200 + 16'(i);
      wr_data = 8'hA0 + 8'(i);
      step();
    end
    wr_valid = 1'b0;
    check("t6_lvl", level, 3);
    n_rdy = 1'b0;
    step();
    check("t6_strobe", n_we, 1'b0);
    rst = 1'b1;
    step();
    check("t6_rst", {n_we, ena, level, a}, {2'b10, 3'd0, 16'h0});
    rst = 1'b0;
    step(10);
    check("t6_quiet", {ena, n_we, busy}, 3'b010);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(299) == 0);
      wr_valid = $urandom_range(1);
      if ($urandom_range(3) != 0) wr_addr = 16'hD000 + 16'($urandom_range(16'h1FFF));
      else wr_addr = 16'($urandom);
      wr_data = 8'($urandom);
      if ($urandom_range(3) == 0) n_rdy = ~n_rdy;
      step();
    end
    rst = 1'b0;
    wr_valid = 1'b0;
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
